// File: rtl/dmem_pkg.sv
// Shared constants for the dmem responder: MMIO window tag, offsets, status bits.
// Latency: n/a (constants and a pure decode function).
// Backpressure: n/a.
package dmem_pkg;

    // Upper 28 address bits that select the MMIO window (addresses -16..-1)
    localparam logic [27:0] MMIO_TAG = 28'hFFFFFFF;

    // MMIO word offsets within the window
    localparam logic [3:0] OFF_CYCLE = 4'd0;
    localparam logic [3:0] OFF_LED   = 4'd1;
    localparam logic [3:0] OFF_TX    = 4'd2;
    localparam logic [3:0] OFF_STAT  = 4'd3;

    // CONSOLE_STAT bit positions; the FIFO count sits from STAT_CNT_LSB upward
    localparam int STAT_EMPTY   = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_CNT_LSB = 8;

    // True when the word address falls inside the MMIO window
    function automatic logic is_mmio(input logic [31:0] addr);
        return addr[31:4] == MMIO_TAG;
    endfunction

endpackage

// File: rtl/console_fifo.sv
// Synchronous FIFO for console bytes, DEPTH a power of two, no fall-through.
// Latency: a push into an empty FIFO shows at dout/!empty one edge later.
// Backpressure: push while full is accepted only together with a pop; otherwise dropped.
module console_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign pop_ok  = pop && !empty;
    // A full FIFO still takes a push when the head leaves on the same edge
    assign push_ok = push && (!full || pop_ok);
    // Head is forced to zero when empty so stale storage never leaks out
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage write; contents need no reset since count gates visibility
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus MMIO (cycle counter, LEDs, console FIFO when DMEM_CONSOLE_EN).
// Latency: q_dmem registered one edge after the address is sampled; stores commit at that edge.
// Backpressure: none on the processor side; console drains via console_valid/console_ready.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic [15:0] leds,
    output logic [7:0]  console_data,
    output logic        console_valid,
    input  logic        console_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]           mem [2**ADDR_WIDTH];
    logic [31:0]           cycle_cnt;
    logic                  mmio_sel;
    logic [3:0]            mmio_off;
    logic [ADDR_WIDTH-1:0] ram_idx;
    logic                  ram_we;
    logic                  led_we;
    logic                  tx_we;
    logic                  stat_we;
    logic [31:0]           stat_rd;
    logic [31:0]           mmio_rd;

    assign mmio_sel = is_mmio(address_dmem);
    assign mmio_off = address_dmem[3:0];
    assign ram_idx  = address_dmem[ADDR_WIDTH-1:0];

    // Write strobes; all are suppressed while reset is asserted
    always_comb begin
        ram_we  = reset && wren && !mmio_sel;
        led_we  = reset && wren && mmio_sel && (mmio_off == OFF_LED);
        tx_we   = reset && wren && mmio_sel && (mmio_off == OFF_TX);
        stat_we = reset && wren && mmio_sel && (mmio_off == OFF_STAT);
    end

    // RAM store port; contents survive reset
    always_ff @(posedge clock) begin
        if (ram_we) begin
            mem[ram_idx] <= data;
        end
    end

    // Free-running cycle counter, wraps at 2^32
    always_ff @(posedge clock) begin
        if (!reset) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    // LED register
    always_ff @(posedge clock) begin
        if (!reset) begin
            leds <= '0;
        end else if (led_we) begin
            leds <= data[15:0];
        end
    end

`ifdef DMEM_CONSOLE_EN
    logic             fifo_empty;
    logic             fifo_full;
    logic             fifo_pop;
    logic             overflow;
    logic [CNT_W-1:0] fifo_count;

    assign fifo_pop      = console_valid && console_ready;
    assign console_valid = !fifo_empty;

    console_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_console_fifo (
        .clock (clock),
        .reset (reset),
        .push  (tx_we),
        .din   (data[7:0]),
        .pop   (fifo_pop),
        .dout  (console_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    // Sticky overflow: set by a dropped push, cleared by any STAT write
    always_ff @(posedge clock) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (stat_we) begin
            overflow <= 1'b0;
        end else if (tx_we && fifo_full && !fifo_pop) begin
            overflow <= 1'b1;
        end
    end

    // Assemble CONSOLE_STAT from FIFO state
    always_comb begin
        stat_rd                            = '0;
        stat_rd[STAT_EMPTY]                = fifo_empty;
        stat_rd[STAT_FULL]                 = fifo_full;
        stat_rd[STAT_OVF]                  = overflow;
        stat_rd[STAT_CNT_LSB +: CNT_W]     = fifo_count;
    end
`else
    logic unused_console;

    assign console_valid  = 1'b0;
    assign console_data   = 8'h00;
    assign stat_rd        = '0;
    assign unused_console = ^{console_ready, tx_we, stat_we};
`endif

    // MMIO read mux; TX and unmapped offsets read zero
    always_comb begin
        mmio_rd = '0;
        case (mmio_off)
            OFF_CYCLE: mmio_rd = cycle_cnt;
            OFF_LED:   mmio_rd = {16'b0, leds};
            OFF_STAT:  mmio_rd = stat_rd;
            default:   mmio_rd = '0;
        endcase
    end

    // Registered read data; RAM read is read-first against a same-edge store
    always_ff @(posedge clock) begin
        if (!reset) begin
            q_dmem <= '0;
        end else begin
            q_dmem <= mmio_sel ? mmio_rd : mem[ram_idx];
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM, aliasing, read-first, MMIO, console FIFO, reset.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: console_ready driven directly by the stimulus.
module tb_dmem_responder;

    logic        clock;
    logic        reset;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;
    logic [15:0] leds;
    logic [7:0]  console_data;
    logic        console_valid;
    logic        console_ready;

    int checks   = 0;
    int failures = 0;

    dmem_responder #(
        .ADDR_WIDTH (12),
        .FIFO_DEPTH (8)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .address_dmem  (address_dmem),
        .data          (data),
        .wren          (wren),
        .q_dmem        (q_dmem),
        .leds          (leds),
        .console_data  (console_data),
        .console_valid (console_valid),
        .console_ready (console_ready)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One bus cycle: present address/data/wren, take one rising edge, settle
    task automatic bus(input logic [31:0] addr, input logic [31:0] wdata, input logic we);
        address_dmem = addr;
        data         = wdata;
        wren         = we;
        @(posedge clock);
        #1;
    endtask

    localparam logic [31:0] A_CYCLE = 32'hFFFF_FFF0;
    localparam logic [31:0] A_LED   = 32'hFFFF_FFF1;
    localparam logic [31:0] A_TX    = 32'hFFFF_FFF2;
    localparam logic [31:0] A_STAT  = 32'hFFFF_FFF3;

    logic [7:0] exp_bytes [8];

    initial begin
        reset         = 1'b0;
        address_dmem  = '0;
        data          = '0;
        wren          = 1'b0;
        console_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // Reset state
        check("rst_q", q_dmem, 32'h0);
        check("rst_leds", {16'h0, leds}, 32'h0);
        check("rst_valid", {31'h0, console_valid}, 32'h0);
        check("rst_cdata", {24'h0, console_data}, 32'h0);

        // Cycle counter: edge k after release reads k-1
        reset = 1'b1;
        address_dmem = A_CYCLE;
        for (int k = 1; k <= 11; k++) begin
            @(posedge clock);
            #1;
            if (k == 10) check("cycle_e10", q_dmem, 32'd9);
            if (k == 11) check("cycle_e11", q_dmem, 32'd10);
        end
        force dut.cycle_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_cnt;
        bus(A_CYCLE, 32'h0, 1'b0);
        check("cycle_max", q_dmem, 32'hFFFF_FFFF);
        bus(A_CYCLE, 32'h0, 1'b0);
        check("cycle_wrap", q_dmem, 32'h0);

        // RAM store/load and aliasing
        bus(32'd5, 32'hDEAD_BEEF, 1'b1);
        bus(32'd5, 32'h0, 1'b0);
        check("ram_load5", q_dmem, 32'hDEAD_BEEF);
        bus(32'd5 + 32'd4096, 32'h0, 1'b0);
        check("ram_alias", q_dmem, 32'hDEAD_BEEF);

        // Read-first on same-word store
        bus(32'd9, 32'd3, 1'b1);
        bus(32'd9, 32'd7, 1'b1);
        check("ram_rdfirst", q_dmem, 32'd3);
        bus(32'd9, 32'h0, 1'b0);
        check("ram_new9", q_dmem, 32'd7);

        // LED register and unmapped offset
        bus(A_LED, 32'hFFFF_A5A5, 1'b1);
        check("led_out", {16'h0, leds}, 32'h0000_A5A5);
        bus(A_LED, 32'h0, 1'b0);
        check("led_read", q_dmem, 32'h0000_A5A5);
        bus(32'hFFFF_FFF7, 32'h1234_5678, 1'b1);
        check("unmapped_rd", q_dmem, 32'h0);
        bus(A_TX, 32'h0, 1'b0);
        check("tx_reads0", q_dmem, 32'h0);

`ifdef DMEM_CONSOLE_EN
        // Fill 8 + one dropped push with the consumer stalled
        console_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            bus(A_TX, 32'(i), 1'b1);
        end
        bus(A_STAT, 32'h0, 1'b0);
        check("stat_full_ovf", q_dmem, 32'h0000_0806);
        check("head_valid", {31'h0, console_valid}, 32'h1);

        // Drain at one byte per cycle
        address_dmem  = 32'h0;
        wren          = 1'b0;
        console_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("drain_seq", {24'h0, console_data}, 32'(i));
            @(posedge clock);
            #1;
        end
        check("drain_empty", {31'h0, console_valid}, 32'h0);
        console_ready = 1'b0;
        bus(A_STAT, 32'h0, 1'b0);
        check("stat_empty_ovf", q_dmem, 32'h0000_0005);
        bus(A_STAT, 32'h0, 1'b1);
        bus(A_STAT, 32'h0, 1'b0);
        check("stat_ovf_clr", q_dmem, 32'h0000_0001);

        // Full FIFO, push and pop on the same edge
        for (int i = 0; i < 8; i++) begin
            bus(A_TX, 32'h10 + 32'(i), 1'b1);
        end
        console_ready = 1'b1;
        bus(A_TX, 32'h41, 1'b1);
        console_ready = 1'b0;
        bus(A_STAT, 32'h0, 1'b0);
        check("stat_full_pp", q_dmem, 32'h0000_0802);
        for (int i = 0; i < 7; i++) exp_bytes[i] = 8'h11 + 8'(i);
        exp_bytes[7] = 8'h41;
        address_dmem  = 32'h0;
        wren          = 1'b0;
        console_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("drain_pp", {24'h0, console_data}, {24'h0, exp_bytes[i]});
            @(posedge clock);
            #1;
        end
        check("drain_pp_empty", {31'h0, console_valid}, 32'h0);
        console_ready = 1'b0;

        // Leave bytes buffered for the reset test
        for (int i = 0; i < 3; i++) begin
            bus(A_TX, 32'h61 + 32'(i), 1'b1);
        end
        check("pre_rst_valid", {31'h0, console_valid}, 32'h1);
`else
        bus(A_TX, 32'h55, 1'b1);
        check("dis_valid", {31'h0, console_valid}, 32'h0);
        check("dis_cdata", {24'h0, console_data}, 32'h0);
        bus(A_STAT, 32'h0, 1'b1);
        bus(A_STAT, 32'h0, 1'b0);
        check("dis_stat", q_dmem, 32'h0);
`endif

        // Reset with a store presented: store to RAM word 5 must be ignored
        bus(A_LED, 32'h0000_A5A5, 1'b1);
        bus(32'd5, 32'h0, 1'b0);
        reset = 1'b0;
        bus(32'd5, 32'h0BAD_0BAD, 1'b1);
        check("rst2_leds", {16'h0, leds}, 32'h0);
        check("rst2_valid", {31'h0, console_valid}, 32'h0);
        check("rst2_q", q_dmem, 32'h0);
        check("rst2_cdata", {24'h0, console_data}, 32'h0);
        reset = 1'b1;
        bus(32'd5, 32'h0, 1'b0);
        check("ram_survives", q_dmem, 32'hDEAD_BEEF);
        check("post_rst_valid", {31'h0, console_valid}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder serving the processor's dmem port (`address_dmem`, `data`, `wren`, `q_dmem`) from the memory side. It provides a word-addressed synchronous RAM plus a small memory-mapped I/O window. The window holds a free-running cycle counter, an LED register and a buffered console output with a valid/ready drain. It sits in the wrapper alongside imem and the register file.

## Interface
- `ADDR_WIDTH`, 12: RAM index width; the RAM holds 2^ADDR_WIDTH 32-bit words.
- `FIFO_DEPTH`, 8: console FIFO entries; must be a power of two, at least 2.
- `clock` in 1: the only clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-low; sampled on the rising edge of `clock`.
- `address_dmem` in 32: word address from the processor.
- `data` in 32: store data.
- `wren` in 1: store enable.
- `q_dmem` out 32: registered read data.
- `leds` out 16: LED register contents.
- `console_data` out 8: head byte of the console FIFO.
- `console_valid` out 1: the FIFO is non-empty.
- `console_ready` in 1: the consumer accepts the head byte.

## Operation
- **Region decode.**
  - MMIO when `address_dmem[31:4] == 28'hFFFFFFF` (addresses -16..-1); the offset is `address_dmem[3:0]`.
  - Otherwise RAM, indexed by `address_dmem[ADDR_WIDTH-1:0]`. Upper bits are ignored, so addresses alias.
- **RAM.**
  - A store writes `data` when `wren` is 1.
  - Every cycle, `q_dmem` registers the addressed word.
  - Read-during-write to the same word returns the old contents (read-first).
  - RAM contents are not cleared by reset.
- **MMIO map** (any offset not listed reads 0 and ignores writes):
  - 0 CYCLE (read-only): reads the counter value before this edge's increment. The counter wraps 32'hFFFFFFFF to 0.
  - 1 LED (read/write): a write loads `data[15:0]`. A read returns `{16'b0, leds}`.
  - 2 CONSOLE_TX (write-only, reads 0): a write pushes `data[7:0]`.
  - 3 CONSOLE_STAT (read-only):
    - bit0 empty, bit1 full, bit2 overflow (sticky).
    - bits[15:8] hold the current count.
    - Any write to offset 3 clears overflow.
- **Console FIFO.**
  - `console_valid = !empty`; `console_data` = head entry.
  - A pop occurs when `console_valid && console_ready` at the edge.
  - A push while full with no simultaneous pop is dropped and sets overflow.
  - Push and pop at the same edge: both take effect and the count is unchanged. This holds when full (the push is accepted) and at count 1.
  - A push while empty appears on `console_valid` after the next edge; there is no fall-through.
  - Pointers wrap modulo FIFO_DEPTH. The count is log2(FIFO_DEPTH)+1 bits.
- **Reset** (`reset` = 0 at an edge):
  - Outputs and state: `q_dmem` = 0, `leds` = 0, counter = 0, FIFO empty, overflow = 0, `console_valid` = 0, `console_data` = 0.
  - A store presented in the same cycle is ignored.
  - Reset mid-drain discards all buffered bytes.

## Timing
- Read latency is one rising edge.
  - The address and `wren` sampled at edge N produce `q_dmem` valid from edge N until edge N+1.
  - The processor latches it on the following falling edge.
- Stores and MMIO side effects commit at the sampling edge.
  - A load at edge N+1 sees a store made at edge N.
- Console throughput is one byte per cycle with `console_ready` held high.
- `console_valid` and `console_data` are registered. They do not depend combinationally on `console_ready`.

## Configuration
- `DMEM_CONSOLE_EN`
  - Defined: the console FIFO, offsets 2 and 3, and the handshake operate as above.
  - Undefined:
    - No FIFO is instantiated.
    - Offsets 2 and 3 read 0 and ignore writes.
    - `console_valid` and `console_data` are tied to 0 and `console_ready` is ignored.
    - The port list is unchanged.

## Structure
- Package `dmem_pkg` holds:
  - The MMIO tag constant `28'hFFFFFFF`.
  - Offset constants `OFF_CYCLE` = 0, `OFF_LED` = 1, `OFF_TX` = 2, `OFF_STAT` = 3.
  - Status bit positions.
- Sub-module `console_fifo`: a parameterised synchronous FIFO.
  - Ports: push, `din`, pop, `dout`, empty, full, count.
  - Instantiated only under `DMEM_CONSOLE_EN`.
- The RAM is an inferred array inside `dmem_responder`.

## Test plan
- Store 32'hDEADBEEF to address 5, then load 5 on the next cycle: `q_dmem` = 32'hDEADBEEF one edge after the load. A load of 5 + 2^ADDR_WIDTH returns the same value (aliasing).
- Store 7 to address 9 while a same-cycle load of 9 holds old value 3: `q_dmem` = 3. The next load of 9 gives 7.
- Release reset, then read CYCLE at edges 10 and 11: values differ by 1. Force the counter to 32'hFFFFFFFF: the next read returns 0.
- With `console_ready` = 0, push 9 bytes with FIFO_DEPTH = 8:
  - STAT reads full = 1, count = 8, overflow = 1.
  - Drain gives bytes 1..8 in order.
  - A write to offset 3 clears overflow.
- With FIFO full and `console_ready` = 1, push 8'h41 in the same cycle as a pop: count stays 8, overflow stays 0, and 8'h41 drains last.
- Write LED 16'hA5A5 and push 3 bytes, then assert `reset` = 0 for one edge: `leds` = 0, `console_valid` = 0, `q_dmem` = 0. RAM word 5 still reads 32'hDEADBEEF.
